// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged release of per-domain resets after the synchronized system reset.
// Optional macro RSTSEQ_REVERSE_ASSERT_EN: soft request shuts domains down in reverse order first.
module reset_sequencer #(
  parameter int NUM_DOMAINS = 4,
  parameter int MIN_ASSERT  = 8,
  parameter int STEP_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_sync_n,
  input  logic                   soft_rst_req,
  output logic [NUM_DOMAINS-1:0] dom_rst_n,
  output logic                   seq_done,
  output logic                   busy
);

  localparam int CNT_MAX = (MIN_ASSERT > STEP_CYCLES) ? MIN_ASSERT : STEP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = ($clog2(NUM_DOMAINS + 1) > 0) ? $clog2(NUM_DOMAINS + 1) : 1;

  // cnt holds the edges already spent, so the release edge sees compare-1
  localparam logic [CW-1:0] MA_LAST  = CW'(MIN_ASSERT - 1);
  localparam logic [CW-1:0] ST_LAST  = CW'(STEP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DOMAINS - 1);

  typedef enum logic [1:0] {
    S_ASSERT   = 2'd0,
    S_RELEASE  = 2'd1,
    S_DONE     = 2'd2,
    S_SHUTDOWN = 2'd3
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [IW-1:0]          r_idx, w_idx_nxt;
  logic [NUM_DOMAINS-1:0] r_dom, w_dom_nxt;
  logic                   r_done, w_done_nxt;
  logic                   r_busy, w_busy_nxt;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      r_state <= S_ASSERT;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_dom   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_dom   <= w_dom_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_ASSERT: begin
        if (r_cnt == MA_LAST) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = IW'(1);
          w_state_nxt = (NUM_DOMAINS == 1) ? S_DONE : S_RELEASE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RELEASE: begin
        if (r_cnt == ST_LAST) begin
          w_cnt_nxt = '0;
          if (r_idx == IDX_LAST) w_state_nxt = S_DONE;
          else                   w_idx_nxt   = r_idx + 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`ifdef RSTSEQ_REVERSE_ASSERT_EN
      S_SHUTDOWN: begin
        if (r_cnt == ST_LAST) begin
          w_cnt_nxt = '0;
          if (r_idx == '0) w_state_nxt = S_ASSERT;
          else             w_idx_nxt   = r_idx - 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`endif
      default: ;
    endcase
`ifdef RSTSEQ_REVERSE_ASSERT_EN
    // a single domain drops at once, so the shutdown phase collapses into ASSERT
    if (soft_rst_req && (r_state != S_SHUTDOWN)) begin
      w_cnt_nxt = '0;
      if (NUM_DOMAINS == 1) begin
        w_state_nxt = S_ASSERT;
      end else begin
        w_state_nxt = S_SHUTDOWN;
        w_idx_nxt   = IW'(NUM_DOMAINS - 2);
      end
    end
`else
    if (soft_rst_req) begin
      w_cnt_nxt   = '0;
      w_state_nxt = S_ASSERT;
    end
`endif
  end

  always_comb begin
    w_dom_nxt  = r_dom;
    w_done_nxt = r_done;
    w_busy_nxt = r_busy;
    case (r_state)
      S_ASSERT: begin
        w_dom_nxt = '0;
        if (r_cnt == MA_LAST) begin
          w_dom_nxt[0] = 1'b1;
          if (NUM_DOMAINS == 1) begin
            w_done_nxt = 1'b1;
            w_busy_nxt = 1'b0;
          end
        end
      end
      S_RELEASE: begin
        if (r_cnt == ST_LAST) begin
          for (int k = 0; k < NUM_DOMAINS; k++)
            if (r_idx == IW'(k)) w_dom_nxt[k] = 1'b1;
          if (r_idx == IDX_LAST) begin
            w_done_nxt = 1'b1;
            w_busy_nxt = 1'b0;
          end
        end
      end
`ifdef RSTSEQ_REVERSE_ASSERT_EN
      S_SHUTDOWN: begin
        if (r_cnt == ST_LAST) begin
          for (int k = 0; k < NUM_DOMAINS; k++)
            if (r_idx == IW'(k)) w_dom_nxt[k] = 1'b0;
        end
      end
`endif
      default: ;
    endcase
`ifdef RSTSEQ_REVERSE_ASSERT_EN
    if (soft_rst_req && (r_state != S_SHUTDOWN)) begin
      w_dom_nxt[NUM_DOMAINS-1] = 1'b0;
      w_done_nxt               = 1'b0;
      w_busy_nxt               = 1'b1;
    end
`else
    if (soft_rst_req) begin
      w_dom_nxt  = '0;
      w_done_nxt = 1'b0;
      w_busy_nxt = 1'b1;
    end
`endif
  end

  assign dom_rst_n = r_dom;
  assign seq_done  = r_done;
  assign busy      = r_busy;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed bench for reset_sequencer (default build and a 1-domain instance).
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_sync_n = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       soft1 = 1'b0;
  logic [3:0] dom;
  logic       done, bsy;
  logic [0:0] dom1;
  logic       done1, bsy1;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  reset_sequencer #(.NUM_DOMAINS(4), .MIN_ASSERT(8), .STEP_CYCLES(16)) u_dut (
    .clk(clk), .rst_sync_n(rst_sync_n), .soft_rst_req(soft_rst_req),
    .dom_rst_n(dom), .seq_done(done), .busy(bsy)
  );

  reset_sequencer #(.NUM_DOMAINS(1), .MIN_ASSERT(2), .STEP_CYCLES(16)) u_dut1 (
    .clk(clk), .rst_sync_n(rst_sync_n), .soft_rst_req(soft1),
    .dom_rst_n(dom1), .seq_done(done1), .busy(bsy1)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {dom, done, busy} packed for compact checks
  function automatic logic [31:0] st();
    return {26'd0, dom, done, bsy};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    step(2);
    chk("reset_state", st(), {26'd0, 4'b0000, 1'b0, 1'b1});
    chk("reset_state_n1", {29'd0, dom1, done1, bsy1}, 32'b001);

    // power-on sequence; edge numbering starts at the next posedge
    rst_sync_n = 1'b1;
    step(1);
    chk("n1_edge1", {29'd0, dom1, done1, bsy1}, 32'b001);
    step(1);
    chk("n1_edge2", {29'd0, dom1, done1, bsy1}, 32'b110);
    step(5);
    chk("po_edge7", st(), {26'd0, 4'b0000, 1'b0, 1'b1});
    step(1);
    chk("po_edge8", st(), {26'd0, 4'b0001, 1'b0, 1'b1});
    step(15);
    chk("po_edge23", st(), {26'd0, 4'b0001, 1'b0, 1'b1});
    step(1);
    chk("po_edge24", st(), {26'd0, 4'b0011, 1'b0, 1'b1});
    step(16);
    chk("po_edge40", st(), {26'd0, 4'b0111, 1'b0, 1'b1});
    step(15);
    chk("po_edge55", st(), {26'd0, 4'b0111, 1'b0, 1'b1});
    step(1);
    chk("po_edge56", st(), {26'd0, 4'b1111, 1'b1, 1'b0});
    step(10);
    chk("po_done_hold", st(), {26'd0, 4'b1111, 1'b1, 1'b0});

    // async reset mid-sequence at edge 30
    rst_sync_n = 1'b0;
    step(1);
    rst_sync_n = 1'b1;
    step(30);
    chk("mid_edge30", st(), {26'd0, 4'b0011, 1'b0, 1'b1});
    #2 rst_sync_n = 1'b0;
    #1;
    chk("async_reset", st(), {26'd0, 4'b0000, 1'b0, 1'b1});
    chk("async_reset_n1", {29'd0, dom1, done1, bsy1}, 32'b001);
    step(1);
    rst_sync_n = 1'b1;
    step(7);
    chk("restart_edge7", st(), {26'd0, 4'b0000, 1'b0, 1'b1});
    step(1);
    chk("restart_edge8", st(), {26'd0, 4'b0001, 1'b0, 1'b1});
    step(48);
    chk("restart_edge56", st(), {26'd0, 4'b1111, 1'b1, 1'b0});

    // soft request from DONE at edge E
    step(3);
    soft_rst_req = 1'b1;
    step(1);
    soft_rst_req = 1'b0;
    chk("soft_E", st(), {26'd0, 4'b0000, 1'b0, 1'b1});
    step(7);
    chk("soft_E7", st(), {26'd0, 4'b0000, 1'b0, 1'b1});
    step(1);
    chk("soft_E8", st(), {26'd0, 4'b0001, 1'b0, 1'b1});
    step(16);
    chk("soft_E24", st(), {26'd0, 4'b0011, 1'b0, 1'b1});
    step(32);
    chk("soft_E56", st(), {26'd0, 4'b1111, 1'b1, 1'b0});

    // pulses at E and E+5 extend the hold; repeat at E+20 during RELEASE
    step(2);
    soft_rst_req = 1'b1;
    step(1);
    soft_rst_req = 1'b0;
    chk("rep_E", st(), {26'd0, 4'b0000, 1'b0, 1'b1});
    step(4);
    soft_rst_req = 1'b1;
    step(1);
    soft_rst_req = 1'b0;
    step(3);
    chk("rep_E8", st(), {26'd0, 4'b0000, 1'b0, 1'b1});
    step(4);
    chk("rep_E12", st(), {26'd0, 4'b0000, 1'b0, 1'b1});
    step(1);
    chk("rep_E13", st(), {26'd0, 4'b0001, 1'b0, 1'b1});
    step(6);
    soft_rst_req = 1'b1;
    step(1);
    soft_rst_req = 1'b0;
    chk("rep_E20", st(), {26'd0, 4'b0000, 1'b0, 1'b1});
    step(7);
    chk("rep_E27", st(), {26'd0, 4'b0000, 1'b0, 1'b1});
    step(1);
    chk("rep_E28", st(), {26'd0, 4'b0001, 1'b0, 1'b1});

    // request held high keeps everything in ASSERT
    soft_rst_req = 1'b1;
    step(20);
    soft_rst_req = 1'b0;
    chk("held_hi", st(), {26'd0, 4'b0000, 1'b0, 1'b1});
    step(7);
    chk("held_rel7", st(), {26'd0, 4'b0000, 1'b0, 1'b1});
    step(1);
    chk("held_rel8", st(), {26'd0, 4'b0001, 1'b0, 1'b1});

    // single-domain instance soft request
    soft1 = 1'b1;
    step(1);
    soft1 = 1'b0;
    chk("n1_soft", {29'd0, dom1, done1, bsy1}, 32'b001);
    step(2);
    chk("n1_soft_rel", {29'd0, dom1, done1, bsy1}, 32'b110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
